// File: rtl/percep_pkg.sv
// Shared definitions for the perceptron training controller and its datapath:
// FSM state encoding and default datapath geometry.
package percep_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DECIDE,
        S_UPDATE,
        S_NEXT,
        S_FIN
    } state_t;

    localparam int DEF_N_FEAT    = 4;
    localparam int DEF_PIP_DEPTH = 3;

endpackage

// File: rtl/percep_vld_pipe.sv
// Valid delay line mirroring the x/w pipeline register plus MAC input stage;
// freezes with the pipeline on stall and reports when nothing is in flight.
module percep_vld_pipe
    import percep_pkg::*;
#(
    parameter int DEPTH = DEF_PIP_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic vld_in,
    output logic vld_out,
    output logic empty
);

    logic [DEPTH-1:0] line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line <= '0;
        end else if (!stall) begin
            line[0] <= vld_in;
            for (int i = 1; i < DEPTH; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign vld_out = line[DEPTH-1];
    assign empty   = (line == '0);

endmodule

// File: rtl/percep_train_ctrl.sv
// Perceptron training sequencer: walks samples/epochs, drives the x/w pipeline
// and MAC, and issues weight updates. Optional perf counters: PERCEP_TRAIN_PERF_EN.
module percep_train_ctrl
    import percep_pkg::*;
#(
    parameter int N_FEAT    = DEF_N_FEAT,
    parameter int FEAT_AW   = 2,
    parameter int N_SAMP    = 16,
    parameter int SAMP_AW   = 4,
    parameter int MAX_EPOCH = 8,
    parameter int EPOCH_W   = 4,
    parameter int PIP_DEPTH = DEF_PIP_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mem_rdy,
    input  logic               acc_neg,
    input  logic               label,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic               rd_en,
    output logic [FEAT_AW-1:0] feat_idx,
    output logic [SAMP_AW-1:0] samp_idx,
    output logic [EPOCH_W-1:0] epoch,
    output logic               stall,
    output logic               mac_clr,
    output logic               mac_en,
    output logic               w_we,
    output logic               upd_add
`ifdef PERCEP_TRAIN_PERF_EN
    ,
    output logic [31:0]        cyc_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    localparam logic [FEAT_AW-1:0] LAST_FEAT  = FEAT_AW'(N_FEAT - 1);
    localparam logic [SAMP_AW-1:0] LAST_SAMP  = SAMP_AW'(N_SAMP - 1);
    localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(MAX_EPOCH - 1);

    state_t state;
    logic   err_flag;
    logic   issue_op;
    logic   pipe_tail;
    logic   pipe_empty;

    // Outputs decode the registered state, so reset clears them immediately.
    always_comb begin
        issue_op = (state == S_FETCH) && mem_rdy;
        busy     = (state != S_IDLE);
        done     = (state == S_FIN);
        rd_en    = issue_op || (state == S_UPDATE);
        stall    = (state == S_FETCH) && !mem_rdy;
        mac_clr  = ((state == S_IDLE) && start) || (state == S_NEXT);
        w_we     = (state == S_UPDATE);
        upd_add  = (state == S_UPDATE) && label;
        mac_en   = pipe_tail && !stall;
    end

    // Only FETCH reads are MAC operands; UPDATE reads feed the weight-update unit.
    percep_vld_pipe #(
        .DEPTH (PIP_DEPTH)
    ) u_vld_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .vld_in  (issue_op),
        .vld_out (pipe_tail),
        .empty   (pipe_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            feat_idx  <= '0;
            samp_idx  <= '0;
            epoch     <= '0;
            err_flag  <= 1'b0;
            converged <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        feat_idx  <= '0;
                        samp_idx  <= '0;
                        epoch     <= '0;
                        err_flag  <= 1'b0;
                        converged <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_rdy) begin
                        if (feat_idx == LAST_FEAT) state <= S_DRAIN;
                        else                       feat_idx <= feat_idx + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty) state <= S_DECIDE;
                end
                // acc_neg=0 predicts class 1, so a match with label is a miss.
                S_DECIDE: begin
                    if (acc_neg == label) begin
                        err_flag <= 1'b1;
                        feat_idx <= '0;
                        state    <= S_UPDATE;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_UPDATE: begin
                    if (feat_idx == LAST_FEAT) state <= S_NEXT;
                    else                       feat_idx <= feat_idx + 1'b1;
                end
                S_NEXT: begin
                    feat_idx <= '0;
                    if (samp_idx != LAST_SAMP) begin
                        samp_idx <= samp_idx + 1'b1;
                        state    <= S_FETCH;
                    end else if (!err_flag) begin
                        converged <= 1'b1;
                        state     <= S_FIN;
                    end else if (epoch == LAST_EPOCH) begin
                        converged <= 1'b0;
                        state     <= S_FIN;
                    end else begin
                        epoch    <= epoch + 1'b1;
                        samp_idx <= '0;
                        err_flag <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PERCEP_TRAIN_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
        end else if ((state == S_IDLE) && start) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (busy && (cyc_cnt != '1))    cyc_cnt   <= cyc_cnt + 1'b1;
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_percep_train_ctrl.sv
// Self-checking bench for percep_train_ctrl: cycle tables on a 1-sample instance,
// then multi-cycle sequences (non-convergence, 3-sample run, abort, start-while-busy).
module tb_percep_train_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, mem_rdy, acc_neg, label, start1, start3, acc_neg3;

    logic       d1_busy, d1_done, d1_conv, d1_rd_en, d1_stall, d1_mac_clr, d1_mac_en, d1_w_we, d1_upd_add;
    logic [1:0] d1_feat;
    logic [0:0] d1_samp;
    logic [3:0] d1_epoch;

    logic       d3_busy, d3_done, d3_conv, d3_rd_en, d3_stall, d3_mac_clr, d3_mac_en, d3_w_we, d3_upd_add;
    logic [1:0] d3_feat;
    logic [1:0] d3_samp;
    logic [3:0] d3_epoch;

`ifdef PERCEP_TRAIN_PERF_EN
    logic [31:0] d1_cyc, d1_stl, d3_cyc, d3_stl;
`endif

    // Error only on sample 1 of epoch 0 (label=1, acc_neg=1 mispredicts).
    assign acc_neg3 = (d3_epoch == 4'd0) && (d3_samp == 2'd1);

    percep_train_ctrl #(.N_SAMP(1), .SAMP_AW(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mem_rdy(mem_rdy), .acc_neg(acc_neg), .label(label),
        .busy(d1_busy), .done(d1_done), .converged(d1_conv), .rd_en(d1_rd_en), .feat_idx(d1_feat),
        .samp_idx(d1_samp), .epoch(d1_epoch), .stall(d1_stall), .mac_clr(d1_mac_clr), .mac_en(d1_mac_en),
        .w_we(d1_w_we), .upd_add(d1_upd_add)
`ifdef PERCEP_TRAIN_PERF_EN
        , .cyc_cnt(d1_cyc), .stall_cnt(d1_stl)
`endif
    );

    percep_train_ctrl #(.N_SAMP(3), .SAMP_AW(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .mem_rdy(mem_rdy), .acc_neg(acc_neg3), .label(label),
        .busy(d3_busy), .done(d3_done), .converged(d3_conv), .rd_en(d3_rd_en), .feat_idx(d3_feat),
        .samp_idx(d3_samp), .epoch(d3_epoch), .stall(d3_stall), .mac_clr(d3_mac_clr), .mac_en(d3_mac_en),
        .w_we(d3_w_we), .upd_add(d3_upd_add)
`ifdef PERCEP_TRAIN_PERF_EN
        , .cyc_cnt(d3_cyc), .stall_cnt(d3_stl)
`endif
    );

    typedef struct {
        logic       start;
        logic       mem_rdy;
        logic [7:0] flags;
        logic [1:0] feat;
    } vec_t;

    vec_t vecs[28];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s1, input logic s3, input logic rdy);
        @(posedge clk);
        #1;
        start1  = s1;
        start3  = s3;
        mem_rdy = rdy;
    endtask

    function automatic logic [7:0] d1Flags();
        return {d1_busy, d1_done, d1_conv, d1_rd_en, d1_stall, d1_mac_clr, d1_mac_en, d1_w_we};
    endfunction

    initial begin
        int  we_cnt, order_bad, upd_bad, wrong_place, next_cnt;
        bit  got;
        logic [3:0] fin_epoch;
        logic       fin_conv;

        // flags = {busy, done, converged, rd_en, stall, mac_clr, mac_en, w_we}
        // Clean single-sample run, mem_rdy always high
        vecs[0]  = '{1'b1, 1'b1, 8'b0000_0100, 2'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'b1001_0000, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'b1001_0000, 2'd1};
        vecs[3]  = '{1'b0, 1'b1, 8'b1001_0000, 2'd2};
        vecs[4]  = '{1'b0, 1'b1, 8'b1001_0010, 2'd3};
        vecs[5]  = '{1'b0, 1'b1, 8'b1000_0010, 2'd3};
        vecs[6]  = '{1'b0, 1'b1, 8'b1000_0010, 2'd3};
        vecs[7]  = '{1'b0, 1'b1, 8'b1000_0010, 2'd3};
        vecs[8]  = '{1'b0, 1'b1, 8'b1000_0000, 2'd3};
        vecs[9]  = '{1'b0, 1'b1, 8'b1000_0000, 2'd3};
        vecs[10] = '{1'b0, 1'b1, 8'b1000_0100, 2'd3};
        vecs[11] = '{1'b0, 1'b1, 8'b1110_0000, 2'd0};
        vecs[12] = '{1'b0, 1'b1, 8'b0010_0000, 2'd0};
        // Same run with mem_rdy low for two cycles at feat_idx=2
        vecs[13] = '{1'b1, 1'b1, 8'b0010_0100, 2'd0};
        vecs[14] = '{1'b0, 1'b1, 8'b1001_0000, 2'd0};
        vecs[15] = '{1'b0, 1'b1, 8'b1001_0000, 2'd1};
        vecs[16] = '{1'b0, 1'b0, 8'b1000_1000, 2'd2};
        vecs[17] = '{1'b0, 1'b0, 8'b1000_1000, 2'd2};
        vecs[18] = '{1'b0, 1'b1, 8'b1001_0000, 2'd2};
        vecs[19] = '{1'b0, 1'b1, 8'b1001_0010, 2'd3};
        vecs[20] = '{1'b0, 1'b1, 8'b1000_0010, 2'd3};
        vecs[21] = '{1'b0, 1'b1, 8'b1000_0010, 2'd3};
        vecs[22] = '{1'b0, 1'b1, 8'b1000_0010, 2'd3};
        vecs[23] = '{1'b0, 1'b1, 8'b1000_0000, 2'd3};
        vecs[24] = '{1'b0, 1'b1, 8'b1000_0000, 2'd3};
        vecs[25] = '{1'b0, 1'b1, 8'b1000_0100, 2'd3};
        vecs[26] = '{1'b0, 1'b1, 8'b1110_0000, 2'd0};
        vecs[27] = '{1'b0, 1'b1, 8'b0010_0000, 2'd0};

        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; mem_rdy = 1'b1; acc_neg = 1'b0; label = 1'b1;
        #3;
        checkOutput("reset d1 flags", {24'd0, d1Flags()}, 32'd0);
        checkOutput("reset d1 counters", {26'd0, d1_feat, d1_epoch}, 32'd0);
        checkOutput("reset d3 state", {d3_busy, d3_done, d3_conv, d3_w_we, d3_samp, d3_epoch}, 10'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            applyStimulus(vecs[i].start, 1'b0, vecs[i].mem_rdy);
            @(negedge clk);
            checkOutput($sformatf("vec%0d flags", i), {24'd0, d1Flags()}, {24'd0, vecs[i].flags});
            checkOutput($sformatf("vec%0d feat_idx", i), {30'd0, d1_feat}, {30'd0, vecs[i].feat});
        end
`ifdef PERCEP_TRAIN_PERF_EN
        checkOutput("perf stall_cnt", d1_stl, 32'd2);
        checkOutput("perf cyc_cnt", d1_cyc, 32'd13);
`endif

        // Never converges: every sample mispredicts, runs to the epoch limit
        label = 1'b0; acc_neg = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        we_cnt = 0; order_bad = 0; upd_bad = 0; got = 0; fin_epoch = '0; fin_conv = 1'b1;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (d1_w_we) begin
                if (d1_feat !== 2'(we_cnt % 4)) order_bad++;
                if (d1_upd_add !== 1'b0) upd_bad++;
                we_cnt++;
            end
            if (d1_done) begin
                got = 1; fin_epoch = d1_epoch; fin_conv = d1_conv;
            end
        end
        checkOutput("C done reached", {31'd0, got}, 32'd1);
        checkOutput("C epoch at FIN", {28'd0, fin_epoch}, 32'd7);
        checkOutput("C converged", {31'd0, fin_conv}, 32'd0);
        checkOutput("C w_we cycles", we_cnt, 32'd32);
        checkOutput("C update feat order errors", order_bad, 32'd0);
        checkOutput("C upd_add errors", upd_bad, 32'd0);
        @(negedge clk);
        checkOutput("C idle after done", {d1_busy, d1_done, d1_conv}, 3'b000);

        // Three samples, error only on sample 1 of epoch 0
        label = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        we_cnt = 0; upd_bad = 0; wrong_place = 0; next_cnt = 0; got = 0; fin_epoch = '0; fin_conv = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (d3_w_we) begin
                we_cnt++;
                if (d3_upd_add !== 1'b1) upd_bad++;
                if (d3_epoch !== 4'd0 || d3_samp !== 2'd1) wrong_place++;
            end
            if (d3_mac_clr && d3_busy) next_cnt++;
            if (d3_done) begin
                got = 1; fin_epoch = d3_epoch; fin_conv = d3_conv;
            end
        end
        checkOutput("D done reached", {31'd0, got}, 32'd1);
        checkOutput("D converged", {31'd0, fin_conv}, 32'd1);
        checkOutput("D epoch at FIN", {28'd0, fin_epoch}, 32'd1);
        checkOutput("D w_we cycles", we_cnt, 32'd4);
        checkOutput("D update outside e0 s1", wrong_place, 32'd0);
        checkOutput("D upd_add errors", upd_bad, 32'd0);
        checkOutput("D samples stepped", next_cnt, 32'd6);

        // Asynchronous abort during UPDATE at feat_idx=1
        label = 1'b0; acc_neg = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (d1_w_we && d1_feat == 2'd1) got = 1;
        end
        checkOutput("E update feat1 reached", {31'd0, got}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("E abort flags", {24'd0, d1Flags()}, 32'd0);
        checkOutput("E abort counters", {25'd0, d1_upd_add, d1_feat, d1_epoch}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start pulse while busy must not restart the run
        label = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (d1_rd_en && d1_feat == 2'd2) got = 1;
        end
        checkOutput("F fetch feat2 reached", {31'd0, got}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("F busy start feat", {30'd0, d1_feat}, 32'd3);
        checkOutput("F busy start mac_clr", {31'd0, d1_mac_clr}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("F drain after ignore", {d1_busy, d1_rd_en}, 2'b10);
        got = 0; fin_conv = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (d1_done) begin
                got = 1; fin_conv = d1_conv;
            end
        end
        checkOutput("F done converged", {got, fin_conv}, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/percep_train_ctrl.md
Name: percep_train_ctrl

Overview:
Training-sequence controller for the perceptron datapath. It steps through samples and epochs, and issues x/w read addresses. It drives the stall input of the x/w pipeline register and tracks in-flight MAC operands. It then classifies each sample from the accumulator sign and, on misclassification, issues a weight-update pass. It sits between the sample/weight memories and the x/w pipeline register + MAC + weight-update unit.

Parameters:
N_FEAT, 4, features per sample including bias term (>=2)
FEAT_AW, 2, feature index width, ceil(log2(N_FEAT))
N_SAMP, 16, samples per epoch (>=1)
SAMP_AW, 4, sample index width, ceil(log2(N_SAMP))
MAX_EPOCH, 8, epoch limit (>=1)
EPOCH_W, 4, epoch counter width, holds MAX_EPOCH-1
PIP_DEPTH, 3, cycles from rd_en to the operand reaching MAC input (pipreg + MAC input stage)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin training; sampled only in IDLE
mem_rdy  in  1  memory can accept a read this cycle
acc_neg  in  1  sign of MAC accumulator; valid in DECIDE
label  in  1  target class of current sample (1 = positive)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when training ends
converged  out  1  last run ended with an error-free epoch
rd_en  out  1  read x[samp_idx][feat_idx] and w[feat_idx]
feat_idx  out  FEAT_AW  feature address
samp_idx  out  SAMP_AW  sample address
epoch  out  EPOCH_W  current epoch
stall  out  1  to x/w pipeline register; holds its contents
mac_clr  out  1  clear accumulator
mac_en  out  1  accumulate the operand at MAC input
w_we  out  1  weight write strobe, address feat_idx
upd_add  out  1  1: w += x, 0: w -= x

Behaviour:
- Reset: state IDLE; all outputs and counters 0, converged included.
- States: IDLE, FETCH, DRAIN, DECIDE, UPDATE, NEXT, FIN.
- IDLE: on start, clear epoch, samp_idx, feat_idx and the error flag; pulse mac_clr for one cycle; go to FETCH. Start has no effect in any other state.
- FETCH: rd_en = mem_rdy.
  - When mem_rdy=1: feat_idx increments. After feat_idx = N_FEAT-1, go to DRAIN.
  - When mem_rdy=0: stall=1 and all counters hold.
- Valid delay line: PIP_DEPTH-bit shift register of rd_en. It shifts only when stall=0. mac_en is the tail bit of the line. Issued operands never reach MAC during a stall.
- DRAIN: stall=0. Leave for DECIDE once the delay line is all zero.
- DECIDE (one cycle): error = (acc_neg == label); acc_neg=0 predicts class 1.
  - On error, set the epoch error flag and go to UPDATE with feat_idx=0.
  - Otherwise go to NEXT.
- UPDATE: w_we=1 and rd_en=1 for N_FEAT consecutive cycles with feat_idx 0..N_FEAT-1. upd_add=label. mem_rdy is ignored because the write port is always ready. Then go to NEXT.
- NEXT (one cycle): pulse mac_clr and reset feat_idx to 0.
  - If samp_idx < N_SAMP-1: samp_idx++ and return to FETCH.
  - At epoch end with the error flag clear: converged=1, go to FIN.
  - At epoch end with epoch = MAX_EPOCH-1: converged=0, go to FIN.
  - Otherwise: epoch++, samp_idx=0, clear the error flag, return to FETCH.
- FIN: done=1 for one cycle, then IDLE. converged holds until the next start.
- Assertion of rst_n mid-run aborts immediately to IDLE. No partial write survives: w_we drops asynchronously.
- Counters never wrap: feat_idx, samp_idx and epoch are bounded by the transitions above.

Optional Feature:
PERCEP_TRAIN_PERF_EN
- Defined: adds 32-bit outputs cyc_cnt and stall_cnt.
  - cyc_cnt counts cycles with busy=1; stall_cnt counts cycles with stall=1.
  - Both clear on start and saturate at all-ones.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package percep_pkg: state encoding constants and default N_FEAT/PIP_DEPTH, shared with the datapath.
- Sub-module percep_vld_pipe: a PIP_DEPTH valid delay line with stall hold and an all-empty flag.

Test Plan:
- N_FEAT=4, N_SAMP=1, mem_rdy=1, acc_neg=0, label=1 -> rd_en for 4 cycles; mac_en on the same 4 cycles, PIP_DEPTH=3 later; no w_we; done with converged=1 after 1 epoch.
- Same setup with label=0 -> 4 cycles of w_we with upd_add=0 each epoch. After MAX_EPOCH=8 epochs, done=1 and converged=0, with epoch=7 at FIN.
- mem_rdy low for 2 cycles at feat_idx=2 -> stall=1 for exactly those 2 cycles and feat_idx holds at 2. Total mac_en count stays 4 and the mac_en pattern stretches by 2.
- N_SAMP=3 with label/acc_neg giving an error only on sample 1 in epoch 0 -> UPDATE only for samp_idx=1 in epoch 0; epoch 1 is clean, so converged=1.
- Reset asserted during UPDATE at feat_idx=1 -> all outputs 0 immediately and state IDLE. A start pulse issued while busy is ignored.
- With PERCEP_TRAIN_PERF_EN defined, run the stall scenario -> stall_cnt=2 and cyc_cnt equals the number of busy cycles.
